iter_job_scheduler: RTL and testbench
=====================================

// Module: iter_job_scheduler
// PURPOSE
//   Shares one iterative multiply/sum datapath between NUM_REQ requesters and sequences it for each job.
//   - Round-robin arbitration picks one pending requester.
//   - The winner's iteration count is latched.
//   - Datapath strobes are driven: read, ld_y, mult, sum, slc_y, done.
//   - The winning requester is acknowledged when its job finishes.
//   - Sits between requester front-ends and the shared datapath; replaces the single-user controller.
// PARAMETERS
//   NUM_REQ  4  number of requesters (>=2)
//   CNT_W    4  width of per-job iteration count
// PORTS
//   clk       in   1                single clock, rising edge
//   rst       in   1                synchronous, active-high reset
//   req       in   NUM_REQ          level request per requester; held until its ack
//   iter_cnt  in   NUM_REQ*CNT_W    per-requester iteration count, slice i = [i*CNT_W +: CNT_W]
//   gnt       out  NUM_REQ          one-hot owner of datapath, held READ..DONE
//   ack       out  NUM_REQ          one-cycle pulse to owner in DONE
//   read      out  1                datapath: load input operand
//   ld_y      out  1                datapath: load y register
//   slc_y     out  1                datapath: y mux selects feedback path
//   mult      out  1                datapath: multiply step
//   sum       out  1                datapath: accumulate step
//   done      out  1                datapath/job complete, one cycle
//   busy      out  1                high in every state except IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, rr pointer=0, counter=0, owner cleared; every output 0.
//     Reset dominates and is taken from any state, including mid-job; the aborted owner receives no ack.
//   - States and one-hot outputs (Moore; all outputs decoded from registered state):
//       IDLE  : no strobes asserted.
//       READ  : read=1.
//       LOAD  : ld_y=1.
//       MULT  : mult=1.
//       SUM   : sum=1.
//       SEL   : slc_y=1, ld_y=1.
//       DONE  : done=1, ack[owner]=1.
//   - Arbitration (IDLE only), when |req:
//     - Winner = first set req at index ptr, ptr+1, ... with wrap-around mod NUM_REQ.
//     - Latch owner and its iter_cnt slice into counter; next state = READ.
//     - In IDLE with no req, stay in IDLE.
//   - READ -> LOAD, unconditionally.
//   - LOAD -> MULT if counter!=0, else DONE (zero-iteration job).
//   - MULT -> SUM -> SEL.
//   - SEL: counter decrements by 1.
//     - Next state = MULT if (counter-1)!=0, else DONE.
//   - DONE -> IDLE.
//     - ptr <= owner+1 (wraps to 0 after NUM_REQ-1).
//     - Owner is cleared on entry to IDLE; gnt=0 in IDLE.
//   - Latency, with N = latched count and READ as cycle 1:
//     - done in cycle 3+3N (N>=1); cycle 3 for N=0.
//     - Grant decision occurs in the IDLE cycle before READ.
//   - Requests are sampled only in IDLE:
//     - A requester dropping req mid-job is ignored; the job completes and acks.
//     - iter_cnt changes after the grant are ignored.
//   - Requester still holding req in the IDLE cycle after its ack is treated as a new job, subject to RR priority.
//   - Count max 2**CNT_W-1 runs fully; the counter never wraps (decrement happens only while nonzero).
//   - Exactly one of read/ld_y-only/mult/sum/slc_y/done is active per non-IDLE state; ld_y is also high in SEL.
// TESTING
//   1. Single requester: req[1]=1, cnt=3.
//      -> gnt=0010 for 12 cycles; strobes R,L,(M,S,SEL)x3,D; done/ack[1] in cycle 12.
//   2. Zero count: req[0], cnt=0.
//      -> READ, LOAD, DONE; no mult/sum/slc_y pulses; ack[0] in cycle 3.
//   3. Contention: req=1111 held forever, all counts 1.
//      -> grant order 0,1,2,3,0; each job 6 cycles + 1 IDLE cycle.
//   4. Wrap: ptr=3, req=1001 simultaneously.
//      -> req 3 first, then req 0.
//   5. Reset mid-job: rst during SUM of a cnt=5 job.
//      -> next cycle all outputs 0, busy=0; no ack; ptr=0, so req[0] wins next.
//   6. Max count: cnt=15 on CNT_W=4.
//      -> exactly 15 mult pulses; done in cycle 48; req drop mid-job still yields ack.

Source files
------------

// File: rtl/iter_job_scheduler.sv
// Purpose: round-robin shares one iterative multiply/sum datapath between NUM_REQ requesters and sequences each job.
// Latency: grant decided in the IDLE cycle; READ is cycle 1, done/ack in cycle 3+3N (cycle 3 when N=0), one IDLE cycle between jobs.
// Backpressure: requesters hold level req until their one-cycle ack; req and iter_cnt are only sampled while IDLE.
module iter_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] iter_cnt,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     read,
    output logic                     ld_y,
    output logic                     slc_y,
    output logic                     mult,
    output logic                     sum,
    output logic                     done,
    output logic                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] MULT = 3'd3;
    localparam logic [2:0] SUM  = 3'd4;
    localparam logic [2:0] SEL  = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner_idx;
    logic [NUM_REQ-1:0] owner_oh;
    logic [CNT_W-1:0]   counter;

    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [CNT_W-1:0]   win_cnt;

    // Round-robin search: first pending request at ptr, ptr+1, ... wrapping mod NUM_REQ.
    always_comb begin
        logic [PTR_W:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_vld && req[cand[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    // Pick the winner's iteration count out of the packed slice vector.
    always_comb begin
        win_cnt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_idx == PTR_W'(j)) begin
                win_cnt = iter_cnt[j*CNT_W +: CNT_W];
            end
        end
    end

    // Job sequencing: READ, LOAD, then N rounds of MULT/SUM/SEL, then DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = win_vld ? READ : IDLE;
            READ:    state_nxt = LOAD;
            LOAD:    state_nxt = (counter != '0) ? MULT : DONE;
            MULT:    state_nxt = SUM;
            SUM:     state_nxt = SEL;
            SEL:     state_nxt = ((counter - CNT_ONE) != '0) ? MULT : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any job in flight without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner, iteration counter and round-robin pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            owner_idx <= '0;
            owner_oh  <= '0;
            counter   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner_idx <= win_idx;
                        owner_oh  <= NUM_REQ'(1) << win_idx;
                        counter   <= win_cnt;
                    end
                end
                SEL: begin
                    // Never decrement past zero so a max count cannot wrap.
                    if (counter != '0) begin
                        counter <= counter - CNT_ONE;
                    end
                end
                DONE: begin
                    owner_oh <= '0;
                    ptr      <= (owner_idx == PTR_LAST) ? '0 : owner_idx + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from registered state; owner_oh is zero whenever IDLE.
    assign read  = (state == READ);
    assign ld_y  = (state == LOAD) || (state == SEL);
    assign slc_y = (state == SEL);
    assign mult  = (state == MULT);
    assign sum   = (state == SUM);
    assign done  = (state == DONE);
    assign busy  = (state != IDLE);
    assign gnt   = owner_oh;
    assign ack   = done ? owner_oh : '0;

endmodule

// File: tb/tb_iter_job_scheduler.sv
// Purpose: self-checking bench for iter_job_scheduler against a queue-based job model.
// Latency: every cycle is compared after the active edge (sampled on the falling edge).
// Backpressure: requesters hold req until ack, then drop or re-request at random.
module tb_iter_job_scheduler;

    localparam int NR = 4;
    localparam int CW = 4;

    // Expected strobe bundle {read, ld_y, slc_y, mult, sum, done} per cycle of a job.
    localparam logic [5:0] S_R = 6'b100000;
    localparam logic [5:0] S_L = 6'b010000;
    localparam logic [5:0] S_M = 6'b000100;
    localparam logic [5:0] S_S = 6'b000010;
    localparam logic [5:0] S_Y = 6'b011000;
    localparam logic [5:0] S_D = 6'b000001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*CW-1:0] iter_cnt = '0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    ack;
    logic             read, ld_y, slc_y, mult, sum, done, busy;
    logic [14:0]      obs;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining strobe sequence of the current job, owner and rr pointer.
    logic [5:0] mq[$];
    int         m_ptr = 0;
    int         m_owner = 0;

    iter_job_scheduler #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .iter_cnt(iter_cnt),
        .gnt(gnt), .ack(ack), .read(read), .ld_y(ld_y), .slc_y(slc_y),
        .mult(mult), .sum(sum), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, ack, read, ld_y, slc_y, mult, sum, done, busy};

    function automatic logic [14:0] expv();
        logic [3:0] g;
        if (mq.size() == 0) return '0;
        g = 4'b0001 << m_owner;
        return {g, (mq[0][0] ? g : 4'b0000), mq[0], 1'b1};
    endfunction

    // One clock: advance the model on the rising edge, return on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ptr = 0;
        end else if (mq.size() == 0) begin
            for (int k = 0; k < NR; k++) begin
                int idx = (m_ptr + k) % NR;
                if (req[idx]) begin
                    int n = int'(iter_cnt[idx*CW +: CW]);
                    m_owner = idx;
                    mq.push_back(S_R);
                    mq.push_back(S_L);
                    repeat (n) begin
                        mq.push_back(S_M);
                        mq.push_back(S_S);
                        mq.push_back(S_Y);
                    end
                    mq.push_back(S_D);
                    break;
                end
            end
        end else begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_ptr = (m_owner + 1) % NR;
        end
        @(negedge clk);
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        int c = 0;
        req = '0;
        while (busy && c < 80) begin
            tick();
            c++;
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL %s_drain obs=%h exp=%h", nm, obs, expv());
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain_timeout busy=%b required=0", nm, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (obs !== 15'd0) begin
                errors++;
                $display("FAIL reset_outputs obs=%h required=0", obs);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_idle obs=%h required=0", obs);
        end
    endtask

    task automatic test_single();
        int gcyc = 0;
        int dcyc = 0;
        req = 4'b0010;
        iter_cnt = 16'h5036;
        iter_cnt[1*CW +: CW] = 4'd3;
        for (int c = 1; c <= 14; c++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL single_cyc%0d obs=%h exp=%h", c, obs, expv());
            end
            if (gnt == 4'b0010) gcyc++;
            if (ack[1] && done && dcyc == 0) dcyc = c;
            if (ack[1]) req = '0;
        end
        checks++;
        if (gcyc != 12) begin errors++; $display("FAIL single_gnt_cycles got=%0d required=12", gcyc); end
        checks++;
        if (dcyc != 12) begin errors++; $display("FAIL single_done_cycle got=%0d required=12", dcyc); end
    endtask

    task automatic test_zero();
        int dcyc = 0;
        int strobes = 0;
        req = 4'b0001;
        iter_cnt[0 +: CW] = 4'd0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL zero_cyc%0d obs=%h exp=%h", c, obs, expv());
            end
            strobes += int'(mult) + int'(sum) + int'(slc_y);
            if (ack[0] && dcyc == 0) dcyc = c;
            if (ack[0]) req = '0;
        end
        checks++;
        if (dcyc != 3) begin errors++; $display("FAIL zero_done_cycle got=%0d required=3", dcyc); end
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL zero_strobes got=%0d required=0", strobes); end
    endtask

    task automatic test_contention();
        int order[$];
        int lens[$];
        int gaps[$];
        int cur = 0;
        int idle = 0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] prev_g = '0;
        pulse_reset();
        req = 4'b1111;
        iter_cnt = 16'h1111;
        for (int c = 1; c <= 35; c++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL contention_cyc%0d obs=%h exp=%h", c, obs, expv());
            end
            if (gnt != 0 && prev_g == 0) begin
                if (order.size() > 0) gaps.push_back(idle);
                order.push_back(oh_idx(gnt));
                idle = 0;
            end
            if (gnt != 0) cur++;
            else begin
                if (cur > 0) lens.push_back(cur);
                cur = 0;
                idle++;
            end
            prev_g = gnt;
        end
        checks++;
        if (order.size() < 5 || lens.size() < 4 || gaps.size() < 4) begin
            errors++;
            $display("FAIL contention_jobs got=%0d required>=5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL contention_order%0d got=%0d required=%0d", i, order[i], exp_order[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lens[i] != 6 || gaps[i] != 1) begin
                    errors++;
                    $display("FAIL contention_timing%0d len=%0d gap=%0d required=6,1", i, lens[i], gaps[i]);
                end
            end
        end
        drain("contention");
    endtask

    task automatic test_wrap();
        int order[$];
        logic [3:0] prev_g = '0;
        pulse_reset();
        req = 4'b0100;
        iter_cnt = '0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL wrap_pre_cyc%0d obs=%h exp=%h", c, obs, expv());
            end
            if (ack[2]) req[2] = 1'b0;
        end
        req = 4'b1001;
        iter_cnt = 16'h1001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL wrap_cyc%0d obs=%h exp=%h", c, obs, expv());
            end
            if (gnt != 0 && prev_g == 0) order.push_back(oh_idx(gnt));
            prev_g = gnt;
            req = req & ~ack;
        end
        checks++;
        if (order.size() != 2 || order[0] != 3 || order[1] != 0) begin
            errors++;
            $display("FAIL wrap_order got_n=%0d first=%0d required=3,0", order.size(),
                     (order.size() > 0) ? order[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        logic ack_seen = 1'b0;
        logic hit = 1'b0;
        int c = 0;
        pulse_reset();
        req = 4'b0010;
        iter_cnt = '0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL rstmid_pre_cyc%0d obs=%h exp=%h", k, obs, expv());
            end
            if (ack[1]) req = '0;
        end
        req = 4'b0100;
        iter_cnt[2*CW +: CW] = 4'd5;
        while (!hit && c < 10) begin
            tick();
            c++;
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL rstmid_job_cyc%0d obs=%h exp=%h", c, obs, expv());
            end
            if (ack != 0) ack_seen = 1'b1;
            if (sum) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rstmid_no_sum got=0 required=1"); end
        rst = 1'b1;
        req = 4'b0101;
        iter_cnt = '0;
        tick();
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL rstmid_outputs obs=%h required=0", obs);
        end
        checks++;
        if (ack_seen) begin errors++; $display("FAIL rstmid_ack got=1 required=0"); end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || obs !== expv()) begin
            errors++;
            $display("FAIL rstmid_next_gnt gnt=%b required=0001 obs=%h exp=%h", gnt, obs, expv());
        end
        drain("rstmid");
    endtask

    task automatic test_max();
        int mults = 0;
        int dcyc = 0;
        req = 4'b1000;
        iter_cnt[3*CW +: CW] = 4'd15;
        for (int c = 1; c <= 52; c++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL max_cyc%0d obs=%h exp=%h", c, obs, expv());
            end
            if (mult) mults++;
            if (ack[3] && dcyc == 0) dcyc = c;
            if (c == 10) begin
                req[3] = 1'b0;
                iter_cnt[3*CW +: CW] = 4'd2;
            end
        end
        checks++;
        if (mults != 15) begin errors++; $display("FAIL max_mults got=%0d required=15", mults); end
        checks++;
        if (dcyc != 48) begin errors++; $display("FAIL max_done_cycle got=%0d required=48", dcyc); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        iter_cnt[i*CW +: CW] = 4'($urandom_range(0, 5));
                    end
                end else if (ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 7) == 0) iter_cnt[i*CW +: CW] = 4'($urandom_range(0, 7));
            end
            rst = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random_cyc%0d obs=%h exp=%h req=%b", c, obs, expv(), req);
            end
        end
        rst = 1'b0;
        drain("random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_contention();
        test_wrap();
        test_reset_mid();
        test_max();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
